// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that funnels NREQ write requesters into one registered register-file write port.
// Optional RF_ZERO_REG_EN: writes to register 0 are accepted but suppressed, hard-wiring it to zero.
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_dest,
    input  logic [DW*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              rf_stall,
    output logic              wr_en,
    output logic [2:0]        wr_dest,
    output logic [DW-1:0]     wr_data,
    output logic [7:0]        wr_sel
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] ptr_next;
    logic [PW:0]   scan;
    logic          found;
    logic [NREQ-1:0] grant;
    logic [2:0]    sel_dest;
    logic [DW-1:0] sel_data;
    logic          wr_en_next;

    // Scan upward from rr_ptr, wrapping modulo NREQ; reset and stall suppress any grant.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        scan    = '0;
        if (rst_n && !rf_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                scan = {1'b0, rr_ptr} + (PW+1)'(k);
                if (scan >= (PW+1)'(NREQ))
                    scan = scan - (PW+1)'(NREQ);
                if (!found && req_valid[scan[PW-1:0]]) begin
                    found   = 1'b1;
                    gnt_idx = scan[PW-1:0];
                end
            end
        end
        if (found)
            grant[gnt_idx] = 1'b1;
    end

    assign req_ready = grant;
    assign ptr_next  = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);

    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_dest = req_dest[3*i +: 3];
                sel_data = req_data[DW*i +: DW];
            end
        end
    end

`ifdef RF_ZERO_REG_EN
    assign wr_en_next = found && (sel_dest != 3'd0);
`else
    assign wr_en_next = found;
`endif

    // Grant stage -> registered write port (one-cycle latency)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_dest <= '0;
            wr_data <= '0;
            wr_sel  <= '0;
            rr_ptr  <= '0;
        end else begin
            wr_en  <= wr_en_next;
            wr_sel <= wr_en_next ? (8'd1 << sel_dest) : 8'h00;
            if (found) begin
                wr_dest <= sel_dest;
                wr_data <= sel_data;
                rr_ptr  <= ptr_next;
            end
        end
    end

endmodule
